minimax_console: RTL and testbench

- Memory-mapped console and halt peripheral on the minimax data bus (addr/wdata/wmask/rreq/rdata), downstream of the core's data port.
- Byte writes to the console address are buffered in a FIFO and serialised on a UART TX line (8N1).
- A write to the halt address latches an exit code and raises a sticky halt flag.
- A status register is readable, so firmware can poll before writing.

---
 rtl/minimax_console.sv | 273 +++++++++++++++++++++++++++
 tb/tb_minimax_console.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/minimax_console.sv
// Console/halt peripheral on the minimax data bus; byte FIFO feeding a UART TX (8N1, or 8E1 with MINIMAX_CONSOLE_PARITY_EN).
// Latency: console write at edge N drives the start bit after edge N+1; status readback is one cycle.
// Backpressure: none on the bus; a write to a full FIFO with no pop is dropped and sets sticky overflow.

module minimax_console_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] count;
    logic             push_acc;
    logic             pop_acc;

    assign count   = wptr - rptr;
    assign full    = (count == PTR_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_vld = !empty;
    assign pop_dat = mem[rptr[AW-1:0]];

    // A pop in the same cycle frees the slot the push will land in.
    assign push_rdy = !full || pop_rdy;
    assign push_acc = push_vld && push_rdy;
    assign pop_acc  = pop_vld && pop_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_acc) wptr <= wptr + PTR_W'(1);
            if (pop_acc)  rptr <= rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

module minimax_console #(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] STATUS_ADDR  = 32'hffff_fff4,
    parameter logic [31:0] CONSOLE_ADDR = 32'hffff_fff8,
    parameter logic [31:0] HALT_ADDR    = 32'hffff_fffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rreq,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        overflow
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef MINIMAX_CONSOLE_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
`else
    localparam logic PARITY_PRESENT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef MINIMAX_CONSOLE_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } tx_state_t;

    typedef struct packed {
        logic [26:0] rsvd;
        logic        parity;
        logic        overflow;
        logic        busy;
        logic        empty;
        logic        full;
    } status_t;

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             tx_nxt;
    logic             last_clk;
`ifdef MINIMAX_CONSOLE_PARITY_EN
    logic             par, par_nxt;
`endif

    logic       wr_en;
    logic       con_push_vld;
    logic       con_push_rdy;
    logic       halt_wr;
    logic       pop_vld;
    logic       pop_rdy;
    logic [7:0] pop_dat;
    logic       fifo_full;
    logic       fifo_empty;
    status_t    status;

    assign wr_en        = (wmask == 4'hf);
    assign con_push_vld = wr_en && (addr == CONSOLE_ADDR);
    assign halt_wr      = wr_en && (addr == HALT_ADDR);

    minimax_console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (con_push_vld),
        .push_rdy (con_push_rdy),
        .push_dat (wdata[7:0]),
        .pop_vld  (pop_vld),
        .pop_rdy  (pop_rdy),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign last_clk = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        pop_rdy     = 1'b0;
`ifdef MINIMAX_CONSOLE_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            S_IDLE: begin
                pop_rdy = 1'b1;
                if (pop_vld) begin
                    shift_nxt   = pop_dat;
                    bit_cnt_nxt = '0;
                    clk_cnt_nxt = '0;
                    state_nxt   = S_START;
`ifdef MINIMAX_CONSOLE_PARITY_EN
                    par_nxt     = ^pop_dat;
`endif
                end
            end
            S_START: begin
                if (last_clk) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = S_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (last_clk) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef MINIMAX_CONSOLE_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end
`ifdef MINIMAX_CONSOLE_PARITY_EN
            S_PARITY: begin
                if (last_clk) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = S_STOP;
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (last_clk) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = S_IDLE;
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                clk_cnt_nxt = '0;
                state_nxt   = S_IDLE;
            end
        endcase

        // tx is decoded from the next state so the line itself comes straight off a flop.
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shift_nxt[0];
`ifdef MINIMAX_CONSOLE_PARITY_EN
            S_PARITY: tx_nxt = par_nxt;
`endif
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_comb begin
        status          = '0;
        status.parity   = PARITY_PRESENT;
        status.overflow = overflow;
        status.busy     = (state != S_IDLE);
        status.empty    = fifo_empty;
        status.full     = fifo_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef MINIMAX_CONSOLE_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
`ifdef MINIMAX_CONSOLE_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata     <= '0;
            halt      <= 1'b0;
            exit_code <= '0;
            overflow  <= 1'b0;
        end else begin
            // Status is sampled from current registers, so a same-cycle write is not yet visible.
            rdata <= (rreq && (addr == STATUS_ADDR)) ? 32'(status) : '0;
            if (halt_wr && !halt) begin
                halt      <= 1'b1;
                exit_code <= wdata;
            end
            if (con_push_vld && !con_push_rdy) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_minimax_console.sv
// Directed bench for minimax_console: UART framing, FIFO fill/overflow, status, halt and reset.
module tb_minimax_console;
    localparam int          CPB    = 4;
    localparam logic [31:0] A_STAT = 32'hffff_fff4;
    localparam logic [31:0] A_CON  = 32'hffff_fff8;
    localparam logic [31:0] A_HALT = 32'hffff_fffc;
`ifdef MINIMAX_CONSOLE_PARITY_EN
    localparam int          NB   = 11;
    localparam logic [31:0] PBIT = 32'h10;
`else
    localparam int          NB   = 10;
    localparam logic [31:0] PBIT = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rreq;
    logic [31:0] rdata;
    logic        tx;
    logic        halt;
    logic [31:0] exit_code;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minimax_console #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8),
        .STATUS_ADDR  (A_STAT),
        .CONSOLE_ADDR (A_CON),
        .HALT_ADDR    (A_HALT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .wmask     (wmask),
        .rreq      (rreq),
        .rdata     (rdata),
        .tx        (tx),
        .halt      (halt),
        .exit_code (exit_code),
        .overflow  (overflow)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle;
        addr  = '0;
        wdata = '0;
        wmask = 4'h0;
        rreq  = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        rreq  = 1'b0;
    endtask

    task automatic status_read(input string tag, input logic [31:0] exp);
        addr  = A_STAT;
        wdata = '0;
        wmask = 4'h0;
        rreq  = 1'b1;
        tick;
        bus_idle;
        check(tag, rdata, exp | PBIT);
    endtask

    // Called at the negedge showing frame cycle 'skip'; returns on the negedge after the stop bit.
    task automatic check_frame(input logic [7:0] b, input int skip);
        logic [NB-1:0] bits;
`ifdef MINIMAX_CONSOLE_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
`else
        bits = {1'b1, b, 1'b0};
`endif
        for (int i = skip; i < NB * CPB; i++) begin
            check($sformatf("tx_%02h_c%0d", b, i), {31'b0, tx}, {31'b0, bits[i / CPB]});
            tick;
        end
    endtask

    task automatic quiet(input int n, input string tag);
        int lows;
        lows = 0;
        repeat (n) begin
            tick;
            if (tx !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus_idle;
        tick;
        tick;
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_rdata", rdata, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_exit", exit_code, 32'h0);
        check("rst_ovf", {31'b0, overflow}, 32'h0);
        reset = 1'b0;
        status_read("rst_status", 32'h2);

        // Single byte: start bit appears one edge after the write edge.
        bus_write(A_CON, 32'h0000_0055, 4'hf);
        tick;
        bus_idle;
        check("lat_n", {31'b0, tx}, 32'h1);
        tick;
        check_frame(8'h55, 0);
        status_read("idle_after_55", 32'h2);

        // Ten back-to-back writes: first pops at once, eight queue, last is dropped.
        for (int i = 0; i < 10; i++) begin
            bus_write(A_CON, 32'hA5A5_A500 | (32'h30 + 32'(i)), 4'hf);
            tick;
        end
        status_read("full_busy", 32'hD);
        check("ovf_sticky", {31'b0, overflow}, 32'h1);
        check_frame(8'h30, 9);
        for (int b = 8'h31; b <= 8'h38; b++) begin
            check("frame_gap", {31'b0, tx}, 32'h1);
            tick;
            check_frame(8'(b), 0);
        end
        status_read("drained", 32'hA);
        quiet(60, "no_dropped_byte");

        // Halt: partial mask ignored, first full write wins.
        bus_write(A_HALT, 32'h0000_0005, 4'h3);
        tick;
        bus_idle;
        check("halt_partial", {31'b0, halt}, 32'h0);
        bus_write(A_HALT, 32'h0000_0000, 4'hf);
        tick;
        bus_idle;
        check("halt_set", {31'b0, halt}, 32'h1);
        check("exit_first", exit_code, 32'h0);
        bus_write(A_HALT, 32'h0000_0007, 4'hf);
        tick;
        bus_idle;
        check("halt_sticky", {31'b0, halt}, 32'h1);
        check("exit_kept", exit_code, 32'h0);

        // Partial console mask, write to status, unmapped write: all no-ops.
        bus_write(A_CON, 32'h0000_0041, 4'h1);
        tick;
        bus_write(A_STAT, 32'h0000_0041, 4'hf);
        tick;
        bus_write(32'h0000_1000, 32'h0000_0041, 4'hf);
        tick;
        bus_idle;
        status_read("masked_status", 32'hA);
        quiet(20, "masked_tx");

        // Reset mid-DATA with three bytes queued.
        for (int i = 0; i < 4; i++) begin
            bus_write(A_CON, 32'hC0 + 32'(i), 4'hf);
            tick;
        end
        bus_idle;
        repeat (10) tick;
        check("pre_reset_data", {31'b0, tx}, 32'h0);
        reset = 1'b1;
        tick;
        check("mid_rst_tx", {31'b0, tx}, 32'h1);
        check("mid_rst_ovf", {31'b0, overflow}, 32'h0);
        check("mid_rst_halt", {31'b0, halt}, 32'h0);
        reset = 1'b0;
        status_read("mid_rst_empty", 32'h2);
        quiet(60, "mid_rst_no_frames");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
